// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Shares the single byte-wide main-memory port between instruction fetch (IF)
// and the load/store stage (MEM). Each granted request is turned into 1, 2 or 4
// byte-serial RAM accesses. Loads and fetches are assembled little-endian, and
// stores are split little-endian. The requester then gets a one-cycle ack.
// MEM has fixed priority over IF. An accepted transaction is never preempted.
// A taken jump (if_flush) aborts a fetch that is pending or in flight.
//
// Ports
//   clk_in, rst_n_in   clock, asynchronous active-low reset
//   rdy_in             global clock enable (the RAM uses the same enable)
//   if_req/if_addr     fetch request and address, held until if_ack
//   if_flush           abort the pending or in-flight fetch
//   if_ack/if_data     one-cycle completion pulse and fetched word
//   mem_req/mem_we     load/store request (held until mem_ack), 1 = store
//   mem_size           0 = byte, 1 = half, 2/3 = word
//   mem_addr/mem_wdata effective address and store data (low bytes used)
//   mem_ack/mem_rdata  one-cycle completion pulse and zero-extended load data
//   ram_a/ram_wr       RAM byte address and write strobe
//   ram_dout/ram_din   RAM write byte, and read byte (valid one cycle after ram_a)
// -----------------------------------------------------------------------------
module mem_ctrl #(
   parameter int ADDR_W = 32,
   parameter int LAT    = 1    // RAM read latency; only 1 is supported
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_ack,
   output logic [31:0]       if_data,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_size,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_ack,
   output logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din
);

   localparam logic [2:0] LAT_C = 3'(LAT);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

   // Number of bytes moved for a given access size. The reserved code is
   // treated as a full word.
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      logic [2:0] n;
      case (sz)
         2'd0:    n = 3'd1;
         2'd1:    n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   // Select byte idx of a little-endian word.
   function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = w[7:0];
         3'd1:    b = w[15:8];
         3'd2:    b = w[23:16];
         3'd3:    b = w[31:24];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Replace byte idx of a little-endian word.
   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] idx,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = w;
      case (idx)
         3'd0:    r[7:0]   = b;
         3'd1:    r[15:8]  = b;
         3'd2:    r[23:16] = b;
         3'd3:    r[31:24] = b;
         default: r = w;
      endcase
      return r;
   endfunction

   // Control and output registers (asynchronously reset)
   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        n_q, n_d;
   logic              is_if_q, is_if_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic              ram_wr_q, ram_wr_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              if_ack_q, if_ack_d;
   logic [31:0]       if_data_q, if_data_d;
   logic              mem_ack_q, mem_ack_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;

   // Operand and assembly registers (no reset; loaded on grant)
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;

   logic [2:0]        nxt_cnt;
   logic [2:0]        cap_idx;
   logic [2:0]        rd_last;
   logic [ADDR_W-1:0] nxt_addr;

   assign nxt_cnt  = cnt_q + 3'd1;
   // The byte on ram_din belongs to the address issued LAT cycles earlier.
   assign cap_idx  = cnt_q - LAT_C;
   assign rd_last  = n_q + LAT_C - 3'd1;
   assign nxt_addr = base_q + {{(ADDR_W-3){1'b0}}, nxt_cnt};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      is_if_d     = is_if_q;
      we_d        = we_q;
      ram_a_d     = '0;
      ram_wr_d    = 1'b0;
      ram_dout_d  = 8'h00;
      if_ack_d    = 1'b0;
      if_data_d   = if_data_q;
      mem_ack_d   = 1'b0;
      mem_rdata_d = mem_rdata_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      buf_d       = buf_q;

      case (state_q)
         IDLE: begin
            // The ack cycle itself is not arbitrated. A requester may still
            // hold req while its ack is high, and that must not start a
            // second transaction.
            if (!(if_ack_q || mem_ack_q)) begin
               if (mem_req) begin
                  base_d  = mem_addr;
                  wdata_d = mem_wdata;
                  n_d     = size_bytes(mem_size);
                  is_if_d = 1'b0;
                  we_d    = mem_we;
                  cnt_d   = 3'd0;
                  buf_d   = 32'h0;
                  ram_a_d = mem_addr;
                  if (mem_we) begin
                     state_d    = WR;
                     ram_wr_d   = 1'b1;
                     ram_dout_d = mem_wdata[7:0];
                  end else begin
                     state_d = RD;
                  end
               end else if (if_req && !if_flush) begin
                  base_d  = if_addr;
                  n_d     = 3'd4;
                  is_if_d = 1'b1;
                  we_d    = 1'b0;
                  cnt_d   = 3'd0;
                  buf_d   = 32'h0;
                  ram_a_d = if_addr;
                  state_d = RD;
               end
            end
         end

         RD: begin
            if (is_if_q && if_flush) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else begin
               if (cnt_q >= LAT_C)
                  buf_d = put_byte(buf_q, cap_idx, ram_din);
               if (cnt_q == rd_last) begin
                  state_d = DONE;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = nxt_cnt;
                  if (nxt_cnt < n_q)
                     ram_a_d = nxt_addr;
               end
            end
         end

         WR: begin
            if (cnt_q == n_q - 3'd1) begin
               state_d = DONE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d      = nxt_cnt;
               ram_a_d    = nxt_addr;
               ram_wr_d   = 1'b1;
               ram_dout_d = get_byte(wdata_q, nxt_cnt);
            end
         end

         DONE: begin
            state_d = IDLE;
            if (is_if_q) begin
               // A jump that arrives while the word is complete still
               // cancels the fetch.
               if (!if_flush) begin
                  if_ack_d  = 1'b1;
                  if_data_d = buf_q;
               end
            end else begin
               mem_ack_d = 1'b1;
               if (!we_q)
                  mem_rdata_d = buf_q;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         n_q         <= 3'd0;
         is_if_q     <= 1'b0;
         we_q        <= 1'b0;
         ram_a_q     <= '0;
         ram_wr_q    <= 1'b0;
         ram_dout_q  <= 8'h00;
         if_ack_q    <= 1'b0;
         if_data_q   <= 32'h0;
         mem_ack_q   <= 1'b0;
         mem_rdata_q <= 32'h0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         is_if_q     <= is_if_d;
         we_q        <= we_d;
         ram_a_q     <= ram_a_d;
         ram_wr_q    <= ram_wr_d;
         ram_dout_q  <= ram_dout_d;
         if_ack_q    <= if_ack_d;
         if_data_q   <= if_data_d;
         mem_ack_q   <= mem_ack_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         base_q  <= base_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
      end
   end

   assign if_ack    = if_ack_q;
   assign if_data   = if_data_q;
   assign mem_ack   = mem_ack_q;
   assign mem_rdata = mem_rdata_q;
   assign ram_a     = ram_a_q;
   assign ram_wr    = ram_wr_q;
   assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//
// Directed bench for mem_ctrl. It uses a small byte RAM model with one cycle of
// read latency, indexed by ram_a[11:0], and it is gated by rdy_in.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_flush;
   logic        if_ack;
   logic [31:0] if_data;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din = 8'h00;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  ram [0:4095];
   logic        pl_we = 1'b0;
   logic [11:0] pl_a  = 12'h0;
   logic [7:0]  pl_d  = 8'h0;
   logic [31:0] addr_log [0:15];

   always #5 clk_in = ~clk_in;

   mem_ctrl #(.ADDR_W(32), .LAT(1)) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .rdy_in    (rdy_in),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_ack    (if_ack),
      .if_data   (if_data),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_size  (mem_size),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ram_a     (ram_a),
      .ram_wr    (ram_wr),
      .ram_dout  (ram_dout),
      .ram_din   (ram_din)
   );

   // RAM model: synchronous write, registered read, frozen when rdy_in is low
   always @(posedge clk_in) begin
      if (pl_we)
         ram[pl_a] <= pl_d;
      else if (rdy_in && ram_wr)
         ram[ram_a[11:0]] <= ram_dout;
      if (rdy_in)
         ram_din <= ram[ram_a[11:0]];
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic poke(input logic [11:0] a, input logic [7:0] d);
      pl_we = 1'b1;
      pl_a  = a;
      pl_d  = d;
      step();
      pl_we = 1'b0;
   endtask

   task automatic idle(input int n);
      if_req  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Steps through the acceptance edge E, then keeps stepping until the chosen
   // ack is seen. k = c means the ack is high in the cycle after edge E+c.
   // k = -1 means the limit expired.
   task automatic wait_ack(input bit want_if, input int limit, output int k, output int wr_cnt);
      k = 0;
      wr_cnt = 0;
      step();
      while (k < limit) begin
         if (k < 16) addr_log[k] = ram_a;
         if (ram_wr) wr_cnt++;
         if (want_if ? if_ack : mem_ack) return;
         step();
         k++;
      end
      k = -1;
   endtask

   task automatic test_reset();
      n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL reset_if_ack: got %b want 0", if_ack); end
      n_cmp++; if (if_data !== 32'h0) begin n_bad++; $display("FAIL reset_if_data: got %h want 00000000", if_data); end
      n_cmp++; if (mem_ack !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ack: got %b want 0", mem_ack); end
      n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_rdata: got %h want 00000000", mem_rdata); end
      n_cmp++; if (ram_a !== 32'h0) begin n_bad++; $display("FAIL reset_ram_a: got %h want 00000000", ram_a); end
      n_cmp++; if (ram_wr !== 1'b0) begin n_bad++; $display("FAIL reset_ram_wr: got %b want 0", ram_wr); end
      n_cmp++; if (ram_dout !== 8'h0) begin n_bad++; $display("FAIL reset_ram_dout: got %h want 00", ram_dout); end
   endtask

   task automatic test_fetch();
      int k, wc;
      if_addr = 32'h100;
      if_req  = 1'b1;
      wait_ack(1'b1, 20, k, wc);
      n_cmp++; if (k !== 6) begin n_bad++; $display("FAIL fetch_latency: got %0d want 6", k); end
      n_cmp++; if (if_data !== 32'h44332211) begin n_bad++; $display("FAIL fetch_data: got %h want 44332211", if_data); end
      n_cmp++; if (wc !== 0) begin n_bad++; $display("FAIL fetch_no_write: got %0d want 0", wc); end
      n_cmp++; if (addr_log[3] !== 32'h103) begin n_bad++; $display("FAIL fetch_addr3: got %h want 00000103", addr_log[3]); end
      if_req = 1'b0;
      step();
      n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL fetch_ack_pulse: got %b want 0", if_ack); end
      idle(2);
   endtask

   task automatic test_store_half();
      int k, wc;
      mem_we    = 1'b1;
      mem_size  = 2'd1;
      mem_addr  = 32'h203;
      mem_wdata = 32'h1234BEEF;
      mem_req   = 1'b1;
      wait_ack(1'b0, 20, k, wc);
      n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL store_latency: got %0d want 3", k); end
      n_cmp++; if (wc !== 2) begin n_bad++; $display("FAIL store_wr_cycles: got %0d want 2", wc); end
      n_cmp++; if (addr_log[1] !== 32'h204) begin n_bad++; $display("FAIL store_addr1: got %h want 00000204", addr_log[1]); end
      n_cmp++; if (ram[12'h203] !== 8'hEF) begin n_bad++; $display("FAIL store_byte0: got %h want EF", ram[12'h203]); end
      n_cmp++; if (ram[12'h204] !== 8'hBE) begin n_bad++; $display("FAIL store_byte1: got %h want BE", ram[12'h204]); end
      n_cmp++; if (ram[12'h205] !== 8'h5A) begin n_bad++; $display("FAIL store_untouched: got %h want 5A", ram[12'h205]); end
      idle(2);
   endtask

   task automatic test_priority();
      int k, wc;
      mem_we   = 1'b0;
      mem_size = 2'd0;
      mem_addr = 32'h10;
      mem_req  = 1'b1;
      if_addr  = 32'h80;
      if_req   = 1'b1;
      wait_ack(1'b0, 20, k, wc);
      n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL prio_mem_latency: got %0d want 3", k); end
      n_cmp++; if (mem_rdata !== 32'h00000080) begin n_bad++; $display("FAIL prio_mem_rdata: got %h want 00000080", mem_rdata); end
      n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL prio_if_early: got %b want 0", if_ack); end
      mem_req = 1'b0;
      // The fetch is accepted one IDLE cycle after the ack cycle, then takes 6.
      wait_ack(1'b1, 20, k, wc);
      n_cmp++; if (k !== 7) begin n_bad++; $display("FAIL prio_if_latency: got %0d want 7", k); end
      n_cmp++; if (if_data !== 32'h81706F5E) begin n_bad++; $display("FAIL prio_if_data: got %h want 81706F5E", if_data); end
      idle(2);
   endtask

   task automatic test_flush();
      int k, wc;
      if_addr = 32'h100;
      if_req  = 1'b1;
      step();
      step();
      step();
      n_cmp++; if (ram_a !== 32'h102) begin n_bad++; $display("FAIL flush_pre_addr: got %h want 00000102", ram_a); end
      if_flush = 1'b1;
      step();
      n_cmp++; if (ram_a !== 32'h0) begin n_bad++; $display("FAIL flush_idle_addr: got %h want 00000000", ram_a); end
      n_cmp++; if (if_ack !== 1'b0) begin n_bad++; $display("FAIL flush_no_ack: got %b want 0", if_ack); end
      if_flush = 1'b0;
      if_addr  = 32'h40;
      wait_ack(1'b1, 20, k, wc);
      n_cmp++; if (k !== 6) begin n_bad++; $display("FAIL flush_refetch_latency: got %0d want 6", k); end
      n_cmp++; if (if_data !== 32'hD4C3B2A1) begin n_bad++; $display("FAIL flush_refetch_data: got %h want D4C3B2A1", if_data); end
      idle(2);
   endtask

   task automatic test_wrap();
      int k, wc;
      if_addr = 32'hFFFFFFFE;
      if_req  = 1'b1;
      wait_ack(1'b1, 20, k, wc);
      n_cmp++; if (addr_log[0] !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL wrap_a0: got %h want FFFFFFFE", addr_log[0]); end
      n_cmp++; if (addr_log[1] !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL wrap_a1: got %h want FFFFFFFF", addr_log[1]); end
      n_cmp++; if (addr_log[2] !== 32'h00000000) begin n_bad++; $display("FAIL wrap_a2: got %h want 00000000", addr_log[2]); end
      n_cmp++; if (addr_log[3] !== 32'h00000001) begin n_bad++; $display("FAIL wrap_a3: got %h want 00000001", addr_log[3]); end
      n_cmp++; if (if_data !== 32'h04030201) begin n_bad++; $display("FAIL wrap_data: got %h want 04030201", if_data); end
      idle(2);
   endtask

   task automatic test_rdy_stall();
      int got;
      got = -1;
      if_addr = 32'h100;
      if_req  = 1'b1;
      step();
      for (int c = 0; c < 20; c++) begin
         if (if_ack) begin
            got = c;
            break;
         end
         rdy_in = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
         step();
      end
      rdy_in = 1'b1;
      n_cmp++; if (got !== 9) begin n_bad++; $display("FAIL rdy_latency: got %0d want 9", got); end
      n_cmp++; if (if_data !== 32'h44332211) begin n_bad++; $display("FAIL rdy_data: got %h want 44332211", if_data); end
      idle(2);
   endtask

   task automatic test_reset_mid_write();
      int k, wc, seen;
      mem_we    = 1'b1;
      mem_size  = 2'd2;
      mem_addr  = 32'h300;
      mem_wdata = 32'hA5A5A5A5;
      mem_req   = 1'b1;
      step();
      step();
      n_cmp++; if (ram_wr !== 1'b1 || ram_a !== 32'h301) begin n_bad++; $display("FAIL rstmid_pre: got wr=%b a=%h want wr=1 a=00000301", ram_wr, ram_a); end
      #2;
      rst_n_in = 1'b0;
      #1;
      n_cmp++; if (ram_wr !== 1'b0) begin n_bad++; $display("FAIL rstmid_ram_wr: got %b want 0", ram_wr); end
      n_cmp++; if (mem_ack !== 1'b0 || if_ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_acks: got mem=%b if=%b want 0 0", mem_ack, if_ack); end
      n_cmp++; if (ram_a !== 32'h0) begin n_bad++; $display("FAIL rstmid_ram_a: got %h want 00000000", ram_a); end
      n_cmp++; if (if_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_if_data: got %h want 00000000", if_data); end
      n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_mem_rdata: got %h want 00000000", mem_rdata); end
      mem_req = 1'b0;
      mem_we  = 1'b0;
      step();
      step();
      rst_n_in = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (mem_ack || if_ack || ram_wr) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_no_partial: got %0d want 0", seen); end
      n_cmp++; if (ram[12'h301] !== 8'h00) begin n_bad++; $display("FAIL rstmid_no_write: got %h want 00", ram[12'h301]); end
      n_cmp++; if (ram[12'h300] !== 8'hA5) begin n_bad++; $display("FAIL rstmid_first_byte: got %h want A5", ram[12'h300]); end
      mem_size = 2'd0;
      mem_addr = 32'h10;
      mem_req  = 1'b1;
      wait_ack(1'b0, 20, k, wc);
      n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL rstmid_after_latency: got %0d want 3", k); end
      n_cmp++; if (mem_rdata !== 32'h00000080) begin n_bad++; $display("FAIL rstmid_after_rdata: got %h want 00000080", mem_rdata); end
      idle(2);
   endtask

   initial begin
      rst_n_in  = 1'b0;
      rdy_in    = 1'b1;
      if_req    = 1'b0;
      if_addr   = 32'h0;
      if_flush  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_size  = 2'd0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      step();
      step();
      test_reset();
      rst_n_in = 1'b1;
      poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
      poke(12'h040, 8'hA1); poke(12'h041, 8'hB2); poke(12'h042, 8'hC3); poke(12'h043, 8'hD4);
      poke(12'h080, 8'h5E); poke(12'h081, 8'h6F); poke(12'h082, 8'h70); poke(12'h083, 8'h81);
      poke(12'h203, 8'h00); poke(12'h204, 8'h00); poke(12'h205, 8'h5A);
      poke(12'h010, 8'h80);
      poke(12'hFFE, 8'h01); poke(12'hFFF, 8'h02); poke(12'h000, 8'h03); poke(12'h001, 8'h04);
      poke(12'h300, 8'h00); poke(12'h301, 8'h00);
      step();
      test_fetch();
      test_store_half();
      test_priority();
      test_flush();
      test_wrap();
      test_rdy_stall();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
